// File: rtl/spi_pkg.sv
// Shared types for the oversampling SPI slave: FSM state encoding and the
// {CPOL,CPHA} mode encodings used when configuring instances.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for one asynchronous pin, with a selectable reset level
// so the synced value matches the pin's idle level out of reset.
module spi_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    // Shift the pin value through the synchronizer chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave running entirely on clk: sclk/cs_n/mosi are synchronized and
// sclk edges are detected by comparing against the previous synced value.
//
// Transmit handshake: a word transfers on a rising clk edge where tx_valid and
// tx_ready are both high; tx_ready is high exactly when the holding register
// is empty, and a holder of tx_valid must keep tx_data stable until then.
module spi_slave_sync
    import spi_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit LSB_FIRST   = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             cs_n,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err,
    output logic             tx_underrun,
    output state_t           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int FW = $clog2(SYNC_STAGES + 1);

    logic             sclk_s, cs_n_s, mosi_s;
    logic             sclk_prev, cs_prev, cs_armed;
    logic [FW-1:0]    flush_cnt;
    logic             flush_done;
    logic             sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic             sample_edge, shift_edge, cs_fall;
    state_t           state_q, state_d;
    logic             do_load, do_sample, do_shift, frame_done, abort_err;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] rx_sr, rx_shifted, tx_sr, hold_q, load_word;
    logic             hold_full, miso_q;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? w[0] : w[WIDTH-1];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return LSB_FIRST ? (w >> 1) : (w << 1);
    endfunction

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .d(cs_n), .q(cs_n_s)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
    );

    assign sclk_rise   = sclk_s & ~sclk_prev;
    assign sclk_fall   = ~sclk_s & sclk_prev;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign flush_done  = (flush_cnt == FW'(SYNC_STAGES));
    // The synchronizer resets to "deselected"; a select only counts once a
    // genuine high has been seen, so reset with cs_n held low never starts a frame.
    assign cs_fall     = cs_armed & cs_prev & ~cs_n_s;
    assign rx_shifted  = LSB_FIRST ? {mosi_s, rx_sr[WIDTH-1:1]} : {rx_sr[WIDTH-2:0], mosi_s};
    assign load_word   = hold_full ? hold_q : '0;

    // Edge history and arming of the select detector after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_prev <= CPOL;
            cs_prev   <= 1'b1;
            flush_cnt <= '0;
            cs_armed  <= 1'b0;
        end else begin
            sclk_prev <= sclk_s;
            cs_prev   <= cs_n_s;
            if (!flush_done) flush_cnt <= flush_cnt + 1'b1;
            if (flush_done && cs_n_s) cs_armed <= 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-cycle datapath controls; deselect overrides everything
    always_comb begin
        state_d    = state_q;
        do_load    = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        frame_done = 1'b0;
        abort_err  = 1'b0;
        if (cs_n_s) begin
            state_d   = IDLE;
            abort_err = (state_q == SHIFT) && (bit_cnt != '0);
        end else begin
            case (state_q)
                IDLE:  if (cs_fall) state_d = LOAD;
                LOAD: begin
                    do_load = 1'b1;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (sample_edge) begin
                        do_sample = 1'b1;
                        if (bit_cnt == CW'(WIDTH - 1)) begin
                            frame_done = 1'b1;
                            state_d    = DONE;
                        end
                    end
                    if (shift_edge) do_shift = 1'b1;
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Transmit holding register; a same-cycle handshake during LOAD is kept for the next frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid && tx_ready) begin
            hold_q    <= tx_data;
            hold_full <= 1'b1;
        end else if (do_load) begin
            hold_full <= 1'b0;
        end
    end

    // Shift registers, bit counter, received word and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            tx_sr       <= '0;
            miso_q      <= 1'b0;
        end else begin
            rx_valid    <= frame_done;
            frame_err   <= abort_err;
            tx_underrun <= do_load & ~hold_full;
            if (do_load) bit_cnt <= '0;
            if (do_sample) begin
                rx_sr   <= rx_shifted;
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (frame_done) rx_data <= rx_shifted;
            if (do_load) begin
                if (!CPHA) begin
                    miso_q <= first_bit(load_word);
                    tx_sr  <= advance(load_word);
                end else begin
                    miso_q <= 1'b0;
                    tx_sr  <= load_word;
                end
            end else if (do_shift) begin
                miso_q <= first_bit(tx_sr);
                tx_sr  <= advance(tx_sr);
            end else if (state_q == IDLE || state_q == DONE) begin
                miso_q <= 1'b0;
            end
        end
    end

    assign tx_ready  = ~hold_full;
    assign busy      = (state_q != IDLE);
    assign miso_oe   = ~cs_n_s;
    assign miso      = miso_q & miso_oe;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: five instances (64-bit mode 0, 8-bit modes 1..3,
// 8-bit LSB-first mode 0) driven one at a time by a bit-level SPI master.
module tb_spi_slave_sync;
    import spi_pkg::*;

    localparam int NI   = 5;
    localparam int SYNC = 2;
    localparam int H    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sclk_a[NI], cs_a[NI], mosi_a[NI], txv_a[NI];
    logic [63:0] txd_a[NI];
    logic        miso_a[NI], oe_a[NI], txr_a[NI], rxv_a[NI];
    logic        busy_a[NI], ferr_a[NI], und_a[NI];
    logic [63:0] rxd_a[NI];
    logic [1:0]  st_a[NI];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rxv_cnt[NI], ferr_cnt[NI], und_cnt[NI];
    logic [63:0] prev_rxd[NI], last_rx[NI];
    logic [63:0] exp_q[$];
    int          exp_i[$];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int         W = (g == 0) ? 64 : 8;
        localparam logic [1:0] M = (g == 1) ? MODE1 : (g == 2) ? MODE2 : (g == 3) ? MODE3 : MODE0;
        logic [W-1:0] rxd;
        logic         miso_w, oe_w, txr_w, rxv_w, busy_w, ferr_w, und_w;
        state_t       st;
        spi_slave_sync #(
            .WIDTH(W), .CPOL(M[1]), .CPHA(M[0]), .LSB_FIRST(g == 4), .SYNC_STAGES(SYNC)
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk_a[g]), .cs_n(cs_a[g]), .mosi(mosi_a[g]),
            .miso(miso_w), .miso_oe(oe_w), .tx_data(txd_a[g][W-1:0]), .tx_valid(txv_a[g]),
            .tx_ready(txr_w), .rx_data(rxd), .rx_valid(rxv_w), .busy(busy_w),
            .frame_err(ferr_w), .tx_underrun(und_w), .state_dbg(st)
        );
        assign rxd_a[g]  = 64'(rxd);
        assign st_a[g]   = st;
        assign miso_a[g] = miso_w;
        assign oe_a[g]   = oe_w;
        assign txr_a[g]  = txr_w;
        assign rxv_a[g]  = rxv_w;
        assign busy_a[g] = busy_w;
        assign ferr_a[g] = ferr_w;
        assign und_a[g]  = und_w;
    end

    function automatic int inst_w(input int i);
        return (i == 0) ? 64 : 8;
    endfunction

    function automatic logic [1:0] inst_mode(input int i);
        case (i)
            1:       return MODE1;
            2:       return MODE2;
            3:       return MODE3;
            default: return MODE0;
        endcase
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input int i);
        check("rst_miso", miso_a[i], 0);
        check("rst_miso_oe", oe_a[i], 0);
        check("rst_rx_valid", rxv_a[i], 0);
        check("rst_rx_data", rxd_a[i], 0);
        check("rst_tx_ready", txr_a[i], 1);
        check("rst_busy", busy_a[i], 0);
        check("rst_frame_err", ferr_a[i], 0);
        check("rst_underrun", und_a[i], 0);
        check("rst_state", st_a[i], IDLE);
    endtask

    // Per-cycle scoreboard: rx words, output masking, pulse counting
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (rst) begin
                    prev_rxd[i] = rxd_a[i];
                end else begin
                    if (!oe_a[i]) check("miso_masked", miso_a[i], 0);
                    if (rxv_a[i]) begin
                        rxv_cnt[i]++;
                        if (exp_q.size() == 0) begin
                            check("rx_valid_unexpected", 1, 0);
                        end else begin
                            check("rx_inst", i, exp_i.pop_front());
                            check("rx_word", rxd_a[i], exp_q.pop_front());
                        end
                    end else begin
                        check("rx_data_stable", rxd_a[i], prev_rxd[i]);
                    end
                    if (ferr_a[i]) ferr_cnt[i]++;
                    if (und_a[i]) und_cnt[i]++;
                    prev_rxd[i] = rxd_a[i];
                end
            end
        end
    end

    // Bit-level master: s_out[k] is the k-th bit on mosi, s_in[k] the k-th bit seen on miso
    task automatic run_frame(input int i, input int nbits, input logic [127:0] s_out,
                             output logic [127:0] s_in, input bit hold_cs);
        logic [1:0] m;
        logic       cpol, cpha;
        m    = inst_mode(i);
        cpol = m[1];
        cpha = m[0];
        s_in = '0;
        cs_a[i] = 1'b0;
        if (!cpha) mosi_a[i] = s_out[0];
        wait_clk(SYNC + 6);
        check("tx_ready_after_load", txr_a[i], 1);
        for (int k = 0; k < nbits; k++) begin
            if (!cpha) begin
                s_in[k]   = miso_a[i];
                sclk_a[i] = ~cpol;
                wait_clk(H);
                sclk_a[i] = cpol;
                if (k + 1 < nbits) mosi_a[i] = s_out[k+1];
                wait_clk(H);
            end else begin
                sclk_a[i] = ~cpol;
                mosi_a[i] = s_out[k];
                wait_clk(H);
                s_in[k]   = miso_a[i];
                sclk_a[i] = cpol;
                wait_clk(H);
            end
        end
        if (!hold_cs) begin
            cs_a[i] = 1'b1;
            wait_clk(SYNC + 8);
        end
    endtask

    // One frame with expectations derived from the frame description
    task automatic do_frame(input int i, input int nbits, input logic [63:0] mword,
                            input logic [127:0] extra, input bit give_tx,
                            input logic [63:0] tx_word, output logic [63:0] got_tx);
        int           w, rxv0, ferr0, und0;
        bit           lsb, nfull;
        logic [63:0]  mask, txw, mw;
        logic [127:0] s_out, s_in, s_exp;
        w     = inst_w(i);
        lsb   = (i == 4);
        mask  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        mw    = mword & mask;
        txw   = give_tx ? (tx_word & mask) : '0;
        nfull = (nbits >= w);
        if (give_tx) begin
            check("tx_ready_empty", txr_a[i], 1);
            txd_a[i] = tx_word & mask;
            txv_a[i] = 1'b1;
            wait_clk(1);
            txv_a[i] = 1'b0;
            check("tx_ready_full", txr_a[i], 0);
        end
        s_out = '0;
        s_exp = '0;
        for (int k = 0; k < nbits; k++) begin
            if (k < w) begin
                s_out[k] = lsb ? mw[k] : mw[w-1-k];
                s_exp[k] = lsb ? txw[k] : txw[w-1-k];
            end else begin
                s_out[k] = extra[k];
            end
        end
        rxv0  = rxv_cnt[i];
        ferr0 = ferr_cnt[i];
        und0  = und_cnt[i];
        if (nfull) begin
            exp_q.push_back(mw);
            exp_i.push_back(i);
        end
        run_frame(i, nbits, s_out, s_in, 1'b0);
        check("miso_stream", s_in, s_exp);
        got_tx = '0;
        for (int k = 0; k < nbits && k < w; k++) got_tx[lsb ? k : w-1-k] = s_in[k];
        check("rx_valid_count", 128'(rxv_cnt[i] - rxv0), 128'(int'(nfull)));
        check("frame_err_count", 128'(ferr_cnt[i] - ferr0), 128'(int'(nbits > 0 && nbits < w)));
        check("underrun_count", 128'(und_cnt[i] - und0), 128'(int'(!give_tx)));
        check("scoreboard_drained", 128'(exp_q.size()), 0);
        exp_q.delete();
        exp_i.delete();
        if (nfull) last_rx[i] = mw;
        check("rx_data_hold", rxd_a[i], last_rx[i]);
        check("tx_ready_idle", txr_a[i], 1);
        check("busy_idle", busy_a[i], 0);
    endtask

    initial begin
        logic [63:0]  got, mw, tw;
        logic [127:0] ex, s_in;
        logic [1:0]   m;
        int           i, nb, r, rxv0, ferr0, und0;

        rst = 1'b1;
        for (int k = 0; k < NI; k++) begin
            m          = inst_mode(k);
            sclk_a[k]  = m[1];
            cs_a[k]    = 1'b1;
            mosi_a[k]  = 1'b0;
            txv_a[k]   = 1'b0;
            txd_a[k]   = '0;
            rxv_cnt[k] = 0;
            ferr_cnt[k] = 0;
            und_cnt[k] = 0;
            last_rx[k] = '0;
        end
        wait_clk(3);
        for (int k = 0; k < NI; k++) check_reset(k);
        rst = 1'b0;
        wait_clk(SYNC + 4);

        // Mode 0, 64-bit reference vectors
        do_frame(0, 64, 64'h133457799BBCDFF1, '0, 1'b1, 64'h0123456789ABCDEF, got);
        check("m0_master_rx", got, 64'h0123456789ABCDEF);
        check("m0_rx_data", rxd_a[0], 64'h133457799BBCDFF1);

        // Modes 1..3 and LSB-first, 8-bit
        for (int k = 1; k < NI; k++) begin
            do_frame(k, 8, 64'h3C, '0, 1'b1, 64'hA5, got);
            check("w8_master_rx", got, 64'hA5);
            check("w8_rx_data", rxd_a[k], 64'h3C);
        end

        // Deselect after 37 bits, then a normal frame
        mw = {$urandom(), $urandom()};
        tw = {$urandom(), $urandom()};
        do_frame(0, 37, mw, '0, 1'b1, tw, got);
        check("abort_keeps_rx", rxd_a[0], 64'h133457799BBCDFF1);
        mw = {$urandom(), $urandom()};
        tw = {$urandom(), $urandom()};
        do_frame(0, 64, mw, '0, 1'b1, tw, got);
        check("after_abort_master_rx", got, tw);

        // Underrun: no handshake, master reads zeros
        mw = {$urandom(), $urandom()};
        do_frame(0, 64, mw, '0, 1'b0, '0, got);
        check("underrun_master_rx", got, 64'h0);

        // 70 clocks in one select window
        mw = {$urandom(), $urandom()};
        tw = {$urandom(), $urandom()};
        ex = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_frame(0, 70, mw, ex, 1'b1, tw, got);
        check("overrun_master_rx", got, tw);

        // Randomized frames across all instances
        for (int n = 0; n < 10; n++) begin
            i  = $urandom_range(0, NI - 1);
            r  = $urandom_range(0, 9);
            if (r < 6)      nb = inst_w(i);
            else if (r < 8) nb = $urandom_range(1, inst_w(i) - 1);
            else            nb = inst_w(i) + $urandom_range(1, 6);
            mw = {$urandom(), $urandom()};
            tw = {$urandom(), $urandom()};
            ex = {$urandom(), $urandom(), $urandom(), $urandom()};
            do_frame(i, nb, mw, ex, ($urandom_range(0, 3) != 0), tw, got);
        end

        // Reset mid-frame with cs_n held low
        txd_a[0] = {$urandom(), $urandom()};
        txv_a[0] = 1'b1;
        wait_clk(1);
        txv_a[0] = 1'b0;
        ex = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_frame(0, 20, ex, s_in, 1'b1);
        check("busy_mid_frame", busy_a[0], 1);
        rst = 1'b1;
        wait_clk(2);
        for (int k = 0; k < NI; k++) check_reset(k);
        rst = 1'b0;
        for (int k = 0; k < NI; k++) last_rx[k] = '0;
        rxv0  = rxv_cnt[0];
        ferr0 = ferr_cnt[0];
        und0  = und_cnt[0];
        wait_clk(SYNC + 6);
        for (int k = 0; k < 10; k++) begin
            sclk_a[0] = 1'b1;
            mosi_a[0] = $urandom_range(0, 1);
            wait_clk(H);
            sclk_a[0] = 1'b0;
            wait_clk(H);
        end
        check("post_rst_state", st_a[0], IDLE);
        check("post_rst_busy", busy_a[0], 0);
        check("post_rst_rx_valid", 128'(rxv_cnt[0] - rxv0), 0);
        check("post_rst_frame_err", 128'(ferr_cnt[0] - ferr0), 0);
        check("post_rst_underrun", 128'(und_cnt[0] - und0), 0);
        check("post_rst_rx_data", rxd_a[0], 0);
        cs_a[0] = 1'b1;
        wait_clk(SYNC + 8);
        mw = {$urandom(), $urandom()};
        tw = {$urandom(), $urandom()};
        do_frame(0, 64, mw, '0, 1'b1, tw, got);
        check("post_rst_master_rx", got, tw);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Parametrised SPI slave that runs entirely on the system clock and oversamples the SPI pins, replacing the dual-edge, SCLK-clocked slave. It supports all four CPOL/CPHA modes, configurable frame width and bit order, and a valid/ready transmit handshake. It reports frame errors and transmit underruns. It sits between the external SPI master and the DES core's 64-bit text registers.

## Interface
- `WIDTH`, 64, frame length in bits (≥2)
- `CPOL`, 0, SCLK idle level
- `CPHA`, 0, 0 = sample on leading edge, 1 = sample on trailing edge
- `LSB_FIRST`, 0, 0 = MSB shifted first on both lines
- `SYNC_STAGES`, 2, synchronizer depth on `sclk`, `cs_n`, `mosi` (≥2)

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `sclk`  in  1  SPI clock from master (asynchronous to `clk`)
- `cs_n`  in  1  chip select, active low
- `mosi`  in  1  master out
- `miso`  out  1  master in; 0 whenever deselected
- `miso_oe`  out  1  pad output enable; high while selected
- `tx_data`  in  WIDTH  word for next frame
- `tx_valid`  in  1  `tx_data` offered
- `tx_ready`  out  1  holding register empty
- `rx_data`  out  WIDTH  last complete received word; held until next frame completes
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated
- `busy`  out  1  state ≠ IDLE
- `frame_err`  out  1  one-cycle pulse: deselect with 0 < bit count < WIDTH
- `tx_underrun`  out  1  one-cycle pulse: frame started with empty holding register

## Operation
- Inputs pass through `SYNC_STAGES` flops. Edges are detected on synced `sclk` against its previous value. Leading edge is rising if `CPOL=0`, else falling. The sample edge is the leading edge if `CPHA=0`, else the trailing edge. The shift edge is the other edge.
- Tx holding register: `tx_valid && tx_ready` captures `tx_data` and clears `tx_ready`. `tx_ready` is set again when the holding register is moved into the shift register.
- FSM (`spi_pkg::state_t`):
  - IDLE → LOAD on synced `cs_n` falling.
  - LOAD, one cycle: tx shift register ← holding if full, else all-zero with a `tx_underrun` pulse. Bit count ← 0. Go to SHIFT. When `CPHA=0`, `miso_q` ← first bit (MSB, or LSB if `LSB_FIRST`) in this cycle.
  - SHIFT:
    - On a sample edge, shift the synced `mosi` into the rx shift register and increment the count.
    - On a shift edge, present the next tx bit. For `CPHA=1` the first shift edge presents the first bit. For `CPHA=0` the shift edge following the last sample is ignored.
    - When the count reaches WIDTH, `rx_data` ← assembled word, pulse `rx_valid`, go to DONE.
  - DONE: ignore all SCLK edges. `miso_q` ← 0.
  - Any state, synced `cs_n` high → IDLE. `frame_err` pulses if leaving SHIFT with count ≠ 0. `rx_data` is unchanged and the partial word is discarded.
- Simultaneous `cs_n` rise and the WIDTH-th sample edge in the same cycle: deselect wins. Discard the word and pulse `frame_err`.
- Counter width is `$clog2(WIDTH+1)`. The count never wraps, because DONE blocks further increments.
- `miso = miso_q & miso_oe`. `miso_oe` = synced `cs_n` low.
- Reset values:
  - State IDLE.
  - `miso`, `miso_oe`, `rx_valid`, `frame_err`, `tx_underrun`, `busy` = 0.
  - `rx_data` = 0.
  - Holding register empty, so `tx_ready` = 1.
  - Synchronizers: `sclk` stages = CPOL, `cs_n` stages = 1, `mosi` stages = 0.
- Reset mid-frame aborts with no pulses. After release, the block waits in IDLE for a fresh `cs_n` falling edge. It does not resume while `cs_n` is still low.

## Timing
- Input-to-action latency is `SYNC_STAGES`+1 `clk` cycles from a pin transition.
- Master constraints:
  - SCLK high and low phases each ≥ 3 `clk` periods, so f_sclk ≤ f_clk/6.
  - For `CPHA=0`: `cs_n` fall to first SCLK edge ≥ `SYNC_STAGES`+3 `clk`.
  - `cs_n` high time between frames ≥ `SYNC_STAGES`+2 `clk`.
- `rx_valid` fires 1 cycle after the synced WIDTH-th sample edge is detected.
- `tx_data` accepted in LOAD is the value captured by the most recent handshake before LOAD. A handshake in the same cycle as LOAD applies to the next frame.

## Structure
- `spi_pkg`: `state_t` (IDLE, LOAD, SHIFT, DONE), and mode localparams `MODE0`..`MODE3` as {CPOL,CPHA} encodings.
- Sub-module `spi_sync`: parametrised N-flop synchronizer with reset value parameter, instantiated once each for `sclk`, `cs_n`, `mosi`.

## Test plan
- Mode 0, WIDTH=64, tx `0x0123456789ABCDEF`, master sends `0x133457799BBCDFF1`:
  - `rx_data`=`0x133457799BBCDFF1` with one `rx_valid` pulse.
  - Master receives `0x0123456789ABCDEF`.
  - `tx_ready` re-asserts after LOAD.
- Modes 1–3, plus `LSB_FIRST=1` with WIDTH=8: tx `0xA5`, rx `0x3C`. Both sides match in every mode.
- Deselect after 37 bits: one `frame_err` pulse, `rx_data` keeps the prior value, no `rx_valid`. The next full frame completes normally.
- No tx handshake before frame: `tx_underrun` pulses, master reads all-zero, rx still completes.
- 70 SCLK cycles in one CS window: `rx_valid` exactly once after 64 bits, `miso`=0 for the 6 extra bits, no `frame_err` on deselect.
- `rst` asserted mid-frame with `cs_n` held low: all outputs return to reset values. No activity until `cs_n` toggles high then low.
